// File: rtl/mips_pkg.sv
// Shared constants for the MIPS pipeline: widths, NOP encoding, reset PC, opcodes.
package mips_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    localparam logic [5:0] OP_BEQ = 6'd4;
    localparam logic [5:0] OP_J   = 6'd2;

    // Branch/jump targets are word addresses; the low two bits are never honoured.
    function automatic logic [XLEN-1:0] wordAlign(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/event_counter.sv
// Wrapping event counter used for the stall and flush performance counters.
module event_counter #(
    parameter int COUNT_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               inc,
    output logic [COUNT_W-1:0] count
);

    // Count one per cycle with inc high; wraps naturally at 2^COUNT_W.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (inc) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC selection, IF/ID pipeline
// register with redirect bubbles, and stall/flush event counters.
//
// IF_ID validity: IFID_valid=1 means IFID_instr/IFID_pcplus4 describe a real
// instruction that ID may act on; IFID_valid=0 marks a bubble (NOP, pcplus4=0).
// There is no ready/backpressure path here: ID stalls fetch through
// PCWrite/IFIDWrite from the hazard unit.
module fetch_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          COUNT_W  = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               PCWrite,
    input  logic               IFIDWrite,
    input  logic               branch_taken,
    input  logic [31:0]        branch_target,
    input  logic               jump,
    input  logic [31:0]        jump_target,
    output logic [31:0]        imem_addr,
    input  logic [31:0]        imem_data,
    output logic [31:0]        IFID_instr,
    output logic [31:0]        IFID_pcplus4,
    output logic               IFID_valid,
    output logic [COUNT_W-1:0] stall_count,
    output logic [COUNT_W-1:0] flush_count
);

    logic [31:0] pcReg;
    logic [31:0] pcPlus4;
    logic [31:0] nextPc;
    logic        redirect;

    assign imem_addr = pcReg;
    assign pcPlus4   = pcReg + 32'd4;

    // A redirect only counts when the branch/jump in ID is real and not stalled:
    // a stalled branch is still comparing stale operands.
    assign redirect = (branch_taken | jump) & PCWrite & IFID_valid;

    // Next-PC selection: branch beats jump beats sequential; stall holds PC.
    always_comb begin
        nextPc = pcReg;
        if (PCWrite) begin
            if (redirect && branch_taken) begin
                nextPc = wordAlign(branch_target);
            end else if (redirect) begin
                nextPc = wordAlign(jump_target);
            end else begin
                nextPc = pcPlus4;
            end
        end
    end

    // PC register.
    always_ff @(posedge clk) begin
        if (reset) begin
            pcReg <= RESET_PC;
        end else begin
            pcReg <= nextPc;
        end
    end

    // IF/ID register: redirect squashes the wrong-path fetch even if IF/ID is
    // held, otherwise load on IFIDWrite, otherwise keep the held instruction.
    always_ff @(posedge clk) begin
        if (reset) begin
            IFID_instr   <= NOP_INSTR;
            IFID_pcplus4 <= '0;
            IFID_valid   <= 1'b0;
        end else if (redirect) begin
            IFID_instr   <= NOP_INSTR;
            IFID_pcplus4 <= '0;
            IFID_valid   <= 1'b0;
        end else if (IFIDWrite) begin
            IFID_instr   <= imem_data;
            IFID_pcplus4 <= pcPlus4;
            IFID_valid   <= 1'b1;
        end
    end

    event_counter #(.COUNT_W(COUNT_W)) stallCounter (
        .clk   (clk),
        .reset (reset),
        .inc   (~PCWrite),
        .count (stall_count)
    );

    event_counter #(.COUNT_W(COUNT_W)) flushCounter (
        .clk   (clk),
        .reset (reset),
        .inc   (redirect),
        .count (flush_count)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table, hand-written corner sequences,
// and random stimulus against a behavioural model of the fetch rules.
module tb_fetch_stage;

    localparam int CW = 4;

    logic          clk;
    logic          reset;
    logic          pcWrite;
    logic          ifidWrite;
    logic          branchTaken;
    logic [31:0]   branchTarget;
    logic          jumpIn;
    logic [31:0]   jumpTarget;
    logic [31:0]   imemAddr;
    logic [31:0]   imemData;
    logic [31:0]   ifidInstr;
    logic [31:0]   ifidPcplus4;
    logic          ifidValid;
    logic [CW-1:0] stallCount;
    logic [CW-1:0] flushCount;

    int testsRun = 0;
    int testsFailed = 0;

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // instruction memory: word at address A is A | 0xA000
    assign imemData = imemAddr | 32'h0000_A000;

    fetch_stage #(.RESET_PC(32'h0000_0000), .COUNT_W(CW)) dut (
        .clk           (clk),
        .reset         (reset),
        .PCWrite       (pcWrite),
        .IFIDWrite     (ifidWrite),
        .branch_taken  (branchTaken),
        .branch_target (branchTarget),
        .jump          (jumpIn),
        .jump_target   (jumpTarget),
        .imem_addr     (imemAddr),
        .imem_data     (imemData),
        .IFID_instr    (ifidInstr),
        .IFID_pcplus4  (ifidPcplus4),
        .IFID_valid    (ifidValid),
        .stall_count   (stallCount),
        .flush_count   (flushCount)
    );

    // behavioural model state
    logic [31:0]   mPc;
    logic [31:0]   mInstr;
    logic [31:0]   mPcp4;
    logic          mValid;
    logic [CW-1:0] mStall;
    logic [CW-1:0] mFlush;

    // scoreboard of expected PCs for the random phase
    logic [31:0] exp_q[$];

    typedef struct {
        logic        rst;
        logic        pw;
        logic        iw;
        logic        bt;
        logic [31:0] btg;
        logic        j;
        logic [31:0] jt;
        logic [31:0] ePc;
        logic [31:0] eInstr;
        logic [31:0] ePcp4;
        logic        eValid;
        logic [3:0]  eStall;
        logic [3:0]  eFlush;
    } vec_t;

    vec_t vecs[$];

    task automatic modelStep(input logic rst, input logic pw, input logic iw,
                             input logic bt, input logic [31:0] btg,
                             input logic j, input logic [31:0] jt);
        logic [31:0] oldPc;
        logic        taken;
        oldPc = mPc;
        if (rst) begin
            mPc = 32'h0; mInstr = 32'h0; mPcp4 = 32'h0; mValid = 1'b0;
            mStall = '0; mFlush = '0;
        end else begin
            taken = (bt || j) && pw && mValid;
            if (pw) begin
                if (taken) mPc = (bt ? btg : jt) & 32'hFFFF_FFFC;
                else       mPc = oldPc + 32'd4;
            end
            if (taken) begin
                mInstr = 32'h0; mPcp4 = 32'h0; mValid = 1'b0;
            end else if (iw) begin
                mInstr = oldPc | 32'h0000_A000; mPcp4 = oldPc + 32'd4; mValid = 1'b1;
            end
            if (!pw)  mStall = mStall + 1'b1;
            if (taken) mFlush = mFlush + 1'b1;
        end
    endtask

    // driver: apply one cycle of inputs, clock it, advance model
    task automatic applyCycle(input logic rst, input logic pw, input logic iw,
                              input logic bt, input logic [31:0] btg,
                              input logic j, input logic [31:0] jt);
        reset = rst; pcWrite = pw; ifidWrite = iw;
        branchTaken = bt; branchTarget = btg; jumpIn = j; jumpTarget = jt;
        @(posedge clk);
        modelStep(rst, pw, iw, bt, btg, j, jt);
        #1;
    endtask

    task automatic checkOut(input string name, input logic [31:0] ePc,
                            input logic [31:0] eInstr, input logic [31:0] ePcp4,
                            input logic eValid, input logic [CW-1:0] eStall,
                            input logic [CW-1:0] eFlush);
        testsRun++;
        if (imemAddr !== ePc || ifidInstr !== eInstr || ifidPcplus4 !== ePcp4 ||
            ifidValid !== eValid || stallCount !== eStall || flushCount !== eFlush) begin
            testsFailed++;
            $display("FAIL %s: got pc=%h instr=%h pcp4=%h v=%b st=%0d fl=%0d want pc=%h instr=%h pcp4=%h v=%b st=%0d fl=%0d",
                     name, imemAddr, ifidInstr, ifidPcplus4, ifidValid, stallCount, flushCount,
                     ePc, eInstr, ePcp4, eValid, eStall, eFlush);
        end
    endtask

    task automatic addVec(input logic rst, input logic pw, input logic iw,
                          input logic bt, input logic [31:0] btg,
                          input logic j, input logic [31:0] jt,
                          input logic [31:0] ePc, input logic [31:0] eInstr,
                          input logic [31:0] ePcp4, input logic eValid,
                          input logic [3:0] eStall, input logic [3:0] eFlush);
        vec_t v;
        v.rst = rst; v.pw = pw; v.iw = iw; v.bt = bt; v.btg = btg; v.j = j; v.jt = jt;
        v.ePc = ePc; v.eInstr = eInstr; v.ePcp4 = ePcp4; v.eValid = eValid;
        v.eStall = eStall; v.eFlush = eFlush;
        vecs.push_back(v);
    endtask

    initial begin
        reset = 1'b1; pcWrite = 1'b1; ifidWrite = 1'b1;
        branchTaken = 1'b0; branchTarget = '0; jumpIn = 1'b0; jumpTarget = '0;
        mPc = '0; mInstr = '0; mPcp4 = '0; mValid = 1'b0; mStall = '0; mFlush = '0;

        // rst pw iw bt btg j jt | pc instr pcp4 valid stall flush
        addVec(1,1,1,0,0,0,0,  32'h00, 32'h0,    32'h00, 0, 0, 0);  // reset
        addVec(0,1,1,0,0,0,0,  32'h04, 32'hA000, 32'h04, 1, 0, 0);  // free run
        addVec(0,1,1,0,0,0,0,  32'h08, 32'hA004, 32'h08, 1, 0, 0);
        addVec(0,1,1,0,0,0,0,  32'h0C, 32'hA008, 32'h0C, 1, 0, 0);
        addVec(0,1,1,0,0,0,0,  32'h10, 32'hA00C, 32'h10, 1, 0, 0);
        addVec(0,0,0,0,0,0,0,  32'h10, 32'hA00C, 32'h10, 1, 1, 0);  // stall x3
        addVec(0,0,0,0,0,0,0,  32'h10, 32'hA00C, 32'h10, 1, 2, 0);
        addVec(0,0,0,0,0,0,0,  32'h10, 32'hA00C, 32'h10, 1, 3, 0);
        addVec(0,1,1,0,0,0,0,  32'h14, 32'hA010, 32'h14, 1, 3, 0);
        addVec(0,1,1,0,0,0,0,  32'h18, 32'hA014, 32'h18, 1, 3, 0);
        addVec(0,1,1,1,32'h40,0,0, 32'h40, 32'h0, 32'h0, 0, 3, 1); // branch
        addVec(0,1,1,0,0,0,0,  32'h44, 32'hA040, 32'h44, 1, 3, 1);
        addVec(0,0,0,1,32'h80,0,0, 32'h44, 32'hA040, 32'h44, 1, 4, 1); // branch while stalled
        addVec(0,1,1,1,32'h80,0,0, 32'h80, 32'h0, 32'h0, 0, 4, 2);     // stall released
        addVec(0,1,1,0,0,0,0,  32'h84, 32'hA080, 32'h84, 1, 4, 2);
        addVec(0,1,1,1,32'h80,1,32'hC0, 32'h80, 32'h0, 32'h0, 0, 4, 3); // branch beats jump
        addVec(0,1,1,0,0,0,0,  32'h84, 32'hA080, 32'h84, 1, 4, 3);
        addVec(0,1,1,0,0,1,32'hC3, 32'hC0, 32'h0, 32'h0, 0, 4, 4);      // jump, low bits dropped
        addVec(0,1,1,0,0,0,0,  32'hC4, 32'hA0C0, 32'hC4, 1, 4, 4);
        addVec(0,1,0,0,0,0,0,  32'hC8, 32'hA0C0, 32'hC4, 1, 4, 4);      // PC moves, IF/ID holds
        addVec(0,1,1,0,0,0,0,  32'hCC, 32'hA0C8, 32'hCC, 1, 4, 4);

        for (int i = 0; i < vecs.size(); i++) begin
            applyCycle(vecs[i].rst, vecs[i].pw, vecs[i].iw, vecs[i].bt, vecs[i].btg,
                       vecs[i].j, vecs[i].jt);
            checkOut($sformatf("vec%0d", i), vecs[i].ePc, vecs[i].eInstr, vecs[i].ePcp4,
                     vecs[i].eValid, vecs[i].eStall[CW-1:0], vecs[i].eFlush[CW-1:0]);
        end

        // stall counter wrap: 17 stalls from reset
        applyCycle(1,1,1,0,0,0,0);
        applyCycle(0,1,1,0,0,0,0);
        for (int i = 0; i < 17; i++) applyCycle(0,0,0,0,0,0,0);
        checkOut("stall_wrap", 32'h04, 32'hA000, 32'h04, 1'b1, 4'd1, 4'd0);

        // PC wrap at top of address space
        applyCycle(0,1,1,0,0,1,32'hFFFF_FFFF);
        checkOut("jump_top", 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0, 4'd1, 4'd1);
        applyCycle(0,1,1,0,0,0,0);
        checkOut("pc_wrap", 32'h0, 32'hFFFF_FFFC, 32'h0, 1'b1, 4'd1, 4'd1);

        // reset during stall, then reset during a redirect request
        applyCycle(0,1,1,0,0,0,0);
        applyCycle(1,0,0,0,0,0,0);
        checkOut("reset_in_stall", 32'h0, 32'h0, 32'h0, 1'b0, 4'd0, 4'd0);
        applyCycle(0,1,1,0,0,0,0);
        applyCycle(1,1,1,1,32'h100,0,0);
        checkOut("reset_in_redirect", 32'h0, 32'h0, 32'h0, 1'b0, 4'd0, 4'd0);

        // random phase against the model; expected PCs go through the scoreboard
        for (int i = 0; i < 400; i++) begin
            logic rst, pw, iw, bt, j;
            logic [31:0] btg, jt;
            rst = ($urandom_range(0, 59) == 0);
            pw  = ($urandom_range(0, 3) != 0);
            iw  = ($urandom_range(0, 4) != 0);
            bt  = mValid && ($urandom_range(0, 5) == 0);
            j   = mValid && ($urandom_range(0, 5) == 0);
            btg = $urandom;
            jt  = $urandom;
            applyCycle(rst, pw, iw, bt, btg, j, jt);
            exp_q.push_back(mPc);
            checkOut($sformatf("rand%0d", i), exp_q.pop_front(), mInstr, mPcp4, mValid,
                     mStall, mFlush);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
